tx_preamble_insert: RTL

Transmit-side preamble inserter for the 802.11a OFDM chain. On each new frame from the upstream IFFT/cyclic-prefix stage it emits the short training sequence (STS) and long training sequence (LTS), generated from on-chip ROMs, then passes the frame's data samples through unchanged. It is the transmit counterpart of the receiver `Synch` block: its output is exactly the preamble that `Synch` detects and aligns to. Both sides use the same Wishbone-style streaming handshake.

---
 rtl/tx_preamble_insert.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/tx_preamble_insert.sv
`default_nettype none
// ============================================================================
// Module   : tx_preamble_insert
// Purpose  : 802.11a transmit preamble inserter. On each new upstream frame,
//            emits the short training sequence (STS_REP x 16 samples) and
//            the long training sequence (32-sample guard plus LTS_REP x 64
//            samples) from on-chip ROMs. It then passes the frame's data
//            samples through unchanged on a Wishbone-style stream.
//            Optional feature macro: TX_IFG_EN (16 trailing zero samples
//            after each frame).
// Revision : 1.0 - initial release
// ============================================================================
module tx_preamble_insert #(
  parameter int STS_REP = 10,
  parameter int LTS_REP = 2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  output logic        ACK_O,
  output logic [31:0] DAT_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STS   = 3'd1,
    S_LTS   = 3'd2,
    S_DATA  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // Value of cnt on the final load of each preamble section.
  localparam logic [7:0] c_STS_LAST = 8'(16 * STS_REP - 1);
  localparam logic [7:0] c_LTS_LAST = 8'(32 + 64 * LTS_REP - 1);
`ifdef TX_IFG_EN
  localparam logic [7:0] c_IFG_LEN  = 8'd16;
`endif

  // STS time-domain samples, round(32768 * x), packed {Im, Re}.
  function automatic logic [31:0] sts_rom(input logic [3:0] idx);
    sts_rom = '0;
    case (idx)
      4'd0:  sts_rom = { 16'sd1507,  16'sd1507};
      4'd1:  sts_rom = { 16'sd66,   -16'sd4325};
      4'd2:  sts_rom = {-16'sd2589, -16'sd426 };
      4'd3:  sts_rom = {-16'sd426,   16'sd4686};
      4'd4:  sts_rom = { 16'sd0,     16'sd3015};
      4'd5:  sts_rom = {-16'sd426,   16'sd4686};
      4'd6:  sts_rom = {-16'sd2589, -16'sd426 };
      4'd7:  sts_rom = { 16'sd66,   -16'sd4325};
      4'd8:  sts_rom = { 16'sd1507,  16'sd1507};
      4'd9:  sts_rom = {-16'sd4325,  16'sd66  };
      4'd10: sts_rom = {-16'sd426,  -16'sd2589};
      4'd11: sts_rom = { 16'sd4686, -16'sd426 };
      4'd12: sts_rom = { 16'sd3015,  16'sd0   };
      4'd13: sts_rom = { 16'sd4686, -16'sd426 };
      4'd14: sts_rom = {-16'sd426,  -16'sd2589};
      4'd15: sts_rom = {-16'sd4325,  16'sd66  };
      default: sts_rom = '0;
    endcase
  endfunction

  // LTS time-domain samples, round(32768 * x), packed {Im, Re}.
  function automatic logic [31:0] lts_rom(input logic [5:0] idx);
    lts_rom = '0;
    case (idx)
      6'd0:  lts_rom = { 16'sd0,     16'sd5112};
      6'd1:  lts_rom = {-16'sd3932, -16'sd164 };
      6'd2:  lts_rom = {-16'sd3637,  16'sd1311};
      6'd3:  lts_rom = { 16'sd2720,  16'sd3178};
      6'd4:  lts_rom = { 16'sd918,   16'sd688 };
      6'd5:  lts_rom = {-16'sd2884,  16'sd1966};
      6'd6:  lts_rom = {-16'sd1802, -16'sd3768};
      6'd7:  lts_rom = {-16'sd3473, -16'sd1245};
      6'd8:  lts_rom = {-16'sd852,   16'sd3211};
      6'd9:  lts_rom = { 16'sd131,   16'sd1737};
      6'd10: lts_rom = {-16'sd3768,  16'sd33  };
      6'd11: lts_rom = {-16'sd1540, -16'sd4489};
      6'd12: lts_rom = {-16'sd1933,  16'sd786 };
      6'd13: lts_rom = {-16'sd492,   16'sd1933};
      6'd14: lts_rom = { 16'sd5276, -16'sd721 };
      6'd15: lts_rom = {-16'sd131,   16'sd3899};
      6'd16: lts_rom = { 16'sd2032,  16'sd2032};
      6'd17: lts_rom = {-16'sd3211,  16'sd1212};
      6'd18: lts_rom = {-16'sd1278, -16'sd1868};
      6'd19: lts_rom = {-16'sd2130, -16'sd4293};
      6'd20: lts_rom = {-16'sd3015,  16'sd2687};
      6'd21: lts_rom = {-16'sd459,   16'sd2294};
      6'd22: lts_rom = {-16'sd2654, -16'sd1966};
      6'd23: lts_rom = { 16'sd721,  -16'sd1835};
      6'd24: lts_rom = { 16'sd4948, -16'sd1147};
      6'd25: lts_rom = { 16'sd557,  -16'sd3998};
      6'd26: lts_rom = { 16'sd688,  -16'sd4162};
      6'd27: lts_rom = { 16'sd2425,  16'sd2458};
      6'd28: lts_rom = {-16'sd1769, -16'sd98  };
      6'd29: lts_rom = {-16'sd3768, -16'sd3015};
      6'd30: lts_rom = {-16'sd3473,  16'sd3015};
      6'd31: lts_rom = {-16'sd3211,  16'sd393 };
      6'd32: lts_rom = { 16'sd0,    -16'sd5112};
      6'd33: lts_rom = { 16'sd3211,  16'sd393 };
      6'd34: lts_rom = { 16'sd3473,  16'sd3015};
      6'd35: lts_rom = { 16'sd3768, -16'sd3015};
      6'd36: lts_rom = { 16'sd1769, -16'sd98  };
      6'd37: lts_rom = {-16'sd2425,  16'sd2458};
      6'd38: lts_rom = {-16'sd688,  -16'sd4162};
      6'd39: lts_rom = {-16'sd557,  -16'sd3998};
      6'd40: lts_rom = {-16'sd4948, -16'sd1147};
      6'd41: lts_rom = {-16'sd721,  -16'sd1835};
      6'd42: lts_rom = { 16'sd2654, -16'sd1966};
      6'd43: lts_rom = { 16'sd459,   16'sd2294};
      6'd44: lts_rom = { 16'sd3015,  16'sd2687};
      6'd45: lts_rom = { 16'sd2130, -16'sd4293};
      6'd46: lts_rom = { 16'sd1278, -16'sd1868};
      6'd47: lts_rom = { 16'sd3211,  16'sd1212};
      6'd48: lts_rom = {-16'sd2032,  16'sd2032};
      6'd49: lts_rom = { 16'sd131,   16'sd3899};
      6'd50: lts_rom = {-16'sd5276, -16'sd721 };
      6'd51: lts_rom = { 16'sd492,   16'sd1933};
      6'd52: lts_rom = { 16'sd1933,  16'sd786 };
      6'd53: lts_rom = { 16'sd1540, -16'sd4489};
      6'd54: lts_rom = { 16'sd3768,  16'sd33  };
      6'd55: lts_rom = {-16'sd131,   16'sd1737};
      6'd56: lts_rom = { 16'sd852,   16'sd3211};
      6'd57: lts_rom = { 16'sd3473, -16'sd1245};
      6'd58: lts_rom = { 16'sd1802, -16'sd3768};
      6'd59: lts_rom = { 16'sd2884,  16'sd1966};
      6'd60: lts_rom = {-16'sd918,   16'sd688 };
      6'd61: lts_rom = {-16'sd2720,  16'sd3178};
      6'd62: lts_rom = { 16'sd3637,  16'sd1311};
      6'd63: lts_rom = { 16'sd3932, -16'sd164 };
      default: lts_rom = '0;
    endcase
  endfunction

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_dat;
  logic        r_stb;
  logic        r_fell;   // CYC_I dropped during this frame; later re-rise ignored

  state_t      w_state_nxt;
  logic [7:0]  w_cnt_nxt;
  logic [31:0] w_dat_nxt;
  logic        w_stb_nxt;
  logic        w_fell_nxt;
  logic        w_adv;
  logic        w_ack;
  logic [5:0]  w_lts_idx;

  // Next-state, output-register load and input-acknowledge decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dat_nxt   = r_dat;
    w_stb_nxt   = r_stb;
    w_fell_nxt  = r_fell;
    w_ack       = 1'b0;
    w_adv       = !r_stb || ACK_I;
    w_lts_idx   = r_cnt[5:0] + 6'd32;

    if (r_state != S_IDLE && !CYC_I) begin
      w_fell_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_fell_nxt = 1'b0;
        if (CYC_I) begin
          w_state_nxt = S_STS;
          w_cnt_nxt   = 8'd0;
        end
      end

      S_STS: begin
        if (w_adv) begin
          w_dat_nxt = sts_rom(r_cnt[3:0]);
          w_stb_nxt = 1'b1;
          w_cnt_nxt = r_cnt + 8'd1;
          if (r_cnt == c_STS_LAST) begin
            w_state_nxt = S_LTS;
            w_cnt_nxt   = 8'd0;
          end
        end
      end

      S_LTS: begin
        if (w_adv) begin
          w_dat_nxt = lts_rom(w_lts_idx);
          w_stb_nxt = 1'b1;
          w_cnt_nxt = r_cnt + 8'd1;
          if (r_cnt == c_LTS_LAST) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = 8'd0;
          end
        end
      end

      S_DATA: begin
        w_ack = CYC_I && STB_I && w_adv && !r_fell;
        if (w_adv) begin
          w_stb_nxt = w_ack;
        end
        if (w_ack) begin
          w_dat_nxt = DAT_I;
        end
        if (!CYC_I || r_fell) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = 8'd0;
        end
      end

      S_DRAIN: begin
`ifdef TX_IFG_EN
        // Each adv retires the pending sample and emits one quiet zero
        // until the tail is complete.
        if (w_adv) begin
          if (r_cnt != c_IFG_LEN) begin
            w_dat_nxt = 32'd0;
            w_stb_nxt = 1'b1;
            w_cnt_nxt = r_cnt + 8'd1;
          end else begin
            w_stb_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
          end
        end
`else
        // Leave on the edge at which the last sample is retired.
        if (w_adv) begin
          w_stb_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end
`endif
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
        w_stb_nxt   = 1'b0;
      end
    endcase
  end

  // State, counter and output register; reset abandons any frame in flight.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_dat   <= 32'd0;
      r_stb   <= 1'b0;
      r_fell  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dat   <= w_dat_nxt;
      r_stb   <= w_stb_nxt;
      r_fell  <= w_fell_nxt;
    end
  end

  assign ACK_O = w_ack;
  assign DAT_O = r_dat;
  assign STB_O = r_stb;
  assign WE_O  = r_stb;
  assign CYC_O = (r_state != S_IDLE);

endmodule
`default_nettype wire
